// File: rtl/odd_even_stream_counter.sv
// Streaming odd/even classifier with a one-deep registered output stage and
// saturating per-class sample counters.
module odd_even_stream_counter #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] num,
  input  logic             mode,
  input  logic             clear,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_num,
  output logic             odd,
  output logic             even,
  output logic [CNT_W-1:0] odd_count,
  output logic [CNT_W-1:0] even_count
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic             out_valid_reg;
  logic [WIDTH-1:0] out_num_reg;
  logic             odd_reg;
  logic             even_reg;
  logic [CNT_W-1:0] odd_cnt_reg;
  logic [CNT_W-1:0] odd_cnt_next;
  logic [CNT_W-1:0] even_cnt_reg;
  logic [CNT_W-1:0] even_cnt_next;

  logic             accept;
  logic             drain;
  logic             cls_odd;
  logic [WIDTH-1:0] xor_chain;

  // Prefix XOR chain; the last element is the parity of the whole word.
  assign xor_chain[0] = num[0];
  generate
    for (genvar gi = 1; gi < WIDTH; gi++) begin : g_parity
      assign xor_chain[gi] = xor_chain[gi-1] ^ num[gi];
    end
  endgenerate

  assign cls_odd  = mode ? xor_chain[WIDTH-1] : num[0];
  assign in_ready = !out_valid_reg || out_ready;
  assign accept   = in_valid && in_ready;
  assign drain    = out_valid_reg && out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_reg <= 1'b0;
      out_num_reg   <= '0;
      odd_reg       <= 1'b0;
      even_reg      <= 1'b0;
    end else if (accept) begin
      out_valid_reg <= 1'b1;
      out_num_reg   <= num;
      odd_reg       <= cls_odd;
      even_reg      <= !cls_odd;
    end else if (drain) begin
      // out_num deliberately keeps the last drained value.
      out_valid_reg <= 1'b0;
      odd_reg       <= 1'b0;
      even_reg      <= 1'b0;
    end
  end

  // Clear zeroes first so that an accepted sample in the same cycle counts as 1.
  always_comb begin
    odd_cnt_next  = clear ? '0 : odd_cnt_reg;
    even_cnt_next = clear ? '0 : even_cnt_reg;
    if (accept) begin
      if (cls_odd) begin
        if (odd_cnt_next != CNT_MAX) odd_cnt_next = odd_cnt_next + 1'b1;
      end else begin
        if (even_cnt_next != CNT_MAX) even_cnt_next = even_cnt_next + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      odd_cnt_reg  <= '0;
      even_cnt_reg <= '0;
    end else begin
      odd_cnt_reg  <= odd_cnt_next;
      even_cnt_reg <= even_cnt_next;
    end
  end

  assign out_valid  = out_valid_reg;
  assign out_num    = out_num_reg;
  assign odd        = odd_reg;
  assign even       = even_reg;
  assign odd_count  = odd_cnt_reg;
  assign even_count = even_cnt_reg;

endmodule

// File: tb/tb_odd_even_stream_counter.sv
// Directed bench for odd_even_stream_counter (WIDTH=4, CNT_W=3 so saturation is reachable).
module tb_odd_even_stream_counter;

  localparam int WIDTH = 4;
  localparam int CNT_W = 3;

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] num;
  logic             mode;
  logic             clear;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_num;
  logic             odd;
  logic             even;
  logic [CNT_W-1:0] odd_count;
  logic [CNT_W-1:0] even_count;

  int checks;
  int errors;

  odd_even_stream_counter #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .num        (num),
    .mode       (mode),
    .clear      (clear),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_num    (out_num),
    .odd        (odd),
    .even       (even),
    .odd_count  (odd_count),
    .even_count (even_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Advance one clock; outputs are then sampled 1 ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic v, input logic [WIDTH-1:0] n,
                         input logic o, input logic e);
    chk({tag, ".valid"}, 32'(out_valid), 32'(v));
    chk({tag, ".num"},   32'(out_num),   32'(n));
    chk({tag, ".odd"},   32'(odd),       32'(o));
    chk({tag, ".even"},  32'(even),      32'(e));
  endtask

  task automatic chk_cnt(input string tag, input int o, input int e);
    chk({tag, ".odd_count"},  32'(odd_count),  32'(o));
    chk({tag, ".even_count"}, 32'(even_count), 32'(e));
  endtask

  logic [WIDTH-1:0] par_vec [4] = '{4'b0011, 4'b0111, 4'b0000, 4'b1111};
  logic             par_odd [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
  logic [WIDTH-1:0] sat_vec [9] = '{4'd1, 4'd3, 4'd5, 4'd7, 4'd9, 4'd11, 4'd13, 4'd15, 4'd1};

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1; in_valid = 1'b0; num = '0; mode = 1'b0; clear = 1'b0; out_ready = 1'b1;
    step();
    step();
    rst = 1'b0;
    chk_out("reset", 1'b0, 4'd0, 1'b0, 1'b0);
    chk_cnt("reset", 0, 0);
    chk("reset.in_ready", 32'(in_ready), 32'd1);

    // Numeric sweep 0..9 at full throughput.
    for (int n = 0; n < 10; n++) begin
      in_valid = 1'b1; num = WIDTH'(n); mode = 1'b0;
      step();
      $display("sweep num=%0d odd=%0b even=%0b", n, odd, even);
      chk_out($sformatf("sweep%0d", n), 1'b1, WIDTH'(n), n[0], !n[0]);
    end
    in_valid = 1'b0;
    chk_cnt("sweep_end", 5, 5);
    step();
    chk_out("sweep_drained", 1'b0, 4'd9, 1'b0, 1'b0);

    clear = 1'b1;
    step();
    clear = 1'b0;
    chk_cnt("clear", 0, 0);

    // Parity mode.
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; num = par_vec[i]; mode = 1'b1;
      step();
      $display("parity num=%b odd=%0b even=%0b", par_vec[i], odd, even);
      chk_out($sformatf("parity%0d", i), 1'b1, par_vec[i], par_odd[i], !par_odd[i]);
    end
    in_valid = 1'b0; mode = 1'b0;
    chk_cnt("parity_end", 1, 3);
    step();

    // Backpressure: 5 held, 6 waits.
    out_ready = 1'b0; in_valid = 1'b1; num = 4'd5;
    step();
    $display("bp accept num=5");
    chk_out("bp_first", 1'b1, 4'd5, 1'b1, 1'b0);
    chk("bp_first.in_ready", 32'(in_ready), 32'd0);
    num = 4'd6;
    for (int c = 0; c < 4; c++) begin
      step();
      chk_out($sformatf("bp_stall%0d", c), 1'b1, 4'd5, 1'b1, 1'b0);
      chk($sformatf("bp_stall%0d.in_ready", c), 32'(in_ready), 32'd0);
      chk_cnt($sformatf("bp_stall%0d", c), 2, 3);
    end
    out_ready = 1'b1;
    #1;
    chk("bp_release.in_ready", 32'(in_ready), 32'd1);
    step();
    $display("bp release num=6 registered");
    chk_out("bp_second", 1'b1, 4'd6, 1'b0, 1'b1);
    chk_cnt("bp_second", 2, 4);
    in_valid = 1'b0;
    step();
    chk_out("bp_drained", 1'b0, 4'd6, 1'b0, 1'b0);

    // Saturation with CNT_W=3, then clear together with an accept.
    clear = 1'b1;
    step();
    clear = 1'b0;
    for (int k = 0; k < 9; k++) begin
      in_valid = 1'b1; num = sat_vec[k];
      step();
      $display("sat num=%0d odd_count=%0d", sat_vec[k], odd_count);
      chk_cnt($sformatf("sat%0d", k), (k + 1 > 7) ? 7 : k + 1, 0);
    end
    clear = 1'b1; num = 4'd2;
    step();
    clear = 1'b0; in_valid = 1'b0;
    chk_cnt("clear_accept", 0, 1);
    chk_out("clear_accept", 1'b1, 4'd2, 1'b0, 1'b1);
    step();

    // Reset with a stalled sample in the output buffer.
    out_ready = 1'b0; in_valid = 1'b1; num = 4'd9;
    step();
    in_valid = 1'b0;
    chk_out("pre_rst", 1'b1, 4'd9, 1'b1, 1'b0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    $display("mid-operation reset applied");
    chk_out("mid_rst", 1'b0, 4'd0, 1'b0, 1'b0);
    chk_cnt("mid_rst", 0, 0);
    chk("mid_rst.in_ready", 32'(in_ready), 32'd1);
    out_ready = 1'b1;
    step();
    chk_out("mid_rst_after", 1'b0, 4'd0, 1'b0, 1'b0);

    // Mode switch while stalled must not reclassify the held sample.
    out_ready = 1'b0; in_valid = 1'b1; num = 4'd3; mode = 1'b1;
    step();
    in_valid = 1'b0; mode = 1'b0;
    chk_out("msw_parity", 1'b1, 4'd3, 1'b0, 1'b1);
    step();
    step();
    chk_out("msw_stalled", 1'b1, 4'd3, 1'b0, 1'b1);
    in_valid = 1'b1; num = 4'd3; mode = 1'b0; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    $display("mode switch num=3 numeric odd=%0b", odd);
    chk_out("msw_numeric", 1'b1, 4'd3, 1'b1, 1'b0);
    chk_cnt("msw_numeric", 1, 1);
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/odd_even_stream_counter.md
Name: odd_even_stream_counter

Overview:
Parametrised, registered successor to the team's combinational odd/even detector. It accepts a stream of WIDTH-bit values over a valid/ready handshake and classifies each one as odd or even. Two classification modes are supported: numeric (LSB) and parity (popcount of ones). The block keeps saturating running counts of odd and even values. It sits between a value producer and any consumer needing per-sample classification plus statistics, and provides a one-deep output buffer with full backpressure.

Parameters:
WIDTH, 4, bit width of num / out_num (>=1)
CNT_W, 8, width of each statistics counter (>=1)

Ports:
clk  input  1  rising-edge clock, sole clock domain
rst  input  1  synchronous, active-high reset
in_valid  input  1  producer presents num
in_ready  output  1  block can accept this cycle
num  input  WIDTH  value to classify
mode  input  1  0 = numeric (odd iff num[0]); 1 = parity (odd iff XOR of all num bits = 1); sampled with num
clear  input  1  synchronous clear of both counters
out_valid  output  1  out_num/odd/even hold a classified sample
out_ready  input  1  consumer takes sample this cycle
out_num  output  WIDTH  registered copy of accepted num
odd  output  1  classification result
even  output  1  classification result
odd_count  output  CNT_W  saturating count of accepted odd samples
even_count  output  CNT_W  saturating count of accepted even samples

Behaviour:
- Reset (rst=1 at a clk edge): out_valid=0, out_num=0, odd=0, even=0, odd_count=0, even_count=0. rst overrides every other input, including an in-flight sample, which is dropped.
- in_ready = !out_valid || out_ready (combinational). No combinational path from in_valid to in_ready.
- accept = in_valid && in_ready; drain = out_valid && out_ready.
- On accept: the next edge sets out_valid=1 and out_num=num. It sets odd and even from num per the sampled mode, with even = !odd. Latency is 1 cycle from accept to out_valid.
- Accept and drain in the same cycle: the new sample replaces the old one, and out_valid stays 1. Full throughput is one sample per cycle.
- Drain without accept: out_valid=0; odd and even forced to 0; out_num holds its last value.
- Neither accept nor drain: all outputs hold. out_num/odd/even are stable while out_valid=1 and out_ready=0.
- When out_valid=1, exactly one of odd/even is 1. When out_valid=0, both are 0.
- Counters update on the same edge that registers the sample, so they already include it when out_valid rises. An odd sample increments odd_count; an even sample increments even_count.
- Saturation: a counter at 2^CNT_W-1 holds its value and never wraps.
- clear=1: both counters go to 0 at the next edge. If an accept happens in the same cycle, the counter matching the accepted sample goes to 1 and the other to 0. clear does not affect out_valid, out_num, odd or even.
- mode may change every cycle. It only matters in accept cycles, and samples already registered are not reclassified.
- in_valid with in_ready=0: no state change. The producer must hold num/mode stable (standard valid/ready rules).
- Parity mode with WIDTH=1 is identical to numeric mode.

Test Plan:
- Sweep with WIDTH=4, mode=0, out_ready=1: send num=0..9, one per cycle. Each out_valid cycle shows out_num=n and odd=n[0]. Final odd_count=5, even_count=5, and out_valid drops one cycle after the last accept.
- Parity mode: mode=1, send 4'b0011, 4'b0111, 4'b0000, 4'b1111. Required odd/even = 0/1, 1/0, 0/1, 0/1. Final odd_count=1, even_count=3.
- Backpressure: hold out_ready=0 after the first accept of num=5. out_valid=1, out_num=5, odd=1 stay stable and in_ready=0 for 4 cycles, and a second num=6 waits. On release, 5 drains and 6 is registered on the same edge, with no loss and no duplication.
- Saturation and clear with CNT_W=3: send 9 odd values. odd_count stops at 7. Then assert clear together with accepting num=2: next cycle odd_count=0 and even_count=1.
- Reset mid-operation: with out_valid=1 and out_ready=0, assert rst for 1 cycle. All outputs are 0 next cycle, in_ready=1, and the dropped sample is never presented.
- Mode switch during stall: accept num=3 with mode=1, then change mode to 0 while stalled. The registered sample keeps odd=0/even=1 (parity result); the next accepted num=3 with mode=0 gives odd=1.
